pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Consumes the per-instruction control flags from the instruction decoder (jump, link, register-jump, branch-taken) and owns the program counter.
- Issues fetch requests to instruction memory and accepts one decoded instruction per fetch over a valid/ready handshake.
- Computes the next PC and produces the JAL link write (return address to $ra).
- Sits between instruction memory, decoder and register file in the CPU datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  out  1  request instruction word at pc
fetch_ack  in  1  instruction memory has returned word for pc
pc  out  32  current fetch address
instr_valid  in  1  decoder control flags and operands valid
instr_ready  out  1  sequencer accepts decoded instruction this cycle
is_jump  in  1  unconditional jump (J or JAL)
is_jal  in  1  link required (JAL)
is_jr  in  1  jump to register
is_branch  in  1  branch condition resolved taken
imm16  in  16  branch offset, signed, in words
target26  in  26  jump target field
rs_data  in  32  JR target register value
ra_wr_en  out  1  one-cycle pulse: write ra_wr_data to register 31
ra_wr_data  out  32  link address
align_err  out  1  one-cycle pulse: JR target misaligned

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc=RESET_PC, fetch_req=0, instr_ready=0, ra_wr_en=0, ra_wr_data=0, align_err=0. Takes effect immediately and abandons any fetch in progress. fetch_ack and instr_valid are ignored while in reset.
- FSM transitions:
  - BOOT -> FETCH unconditionally on the first clk edge after rst_n deasserts.
  - FETCH: fetch_req=1. Go to DECODE on fetch_ack=1; otherwise hold. pc is stable throughout FETCH.
  - DECODE: instr_ready=1, fetch_req=0. Instruction is accepted on an edge where instr_valid=1. On acceptance, pc<=next_pc and go to FETCH. Otherwise hold, with pc stable.
- fetch_ack outside FETCH and instr_valid outside DECODE are ignored.
- next_pc definitions (pc4 = pc+4, all arithmetic 32-bit modulo 2^32, wrap silent):
  - is_jr: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, pulse align_err.
  - else is_jump or is_jal: {pc4[31:28],target26,2'b00}.
  - else is_branch: pc4 + {{14{imm16[15]}},imm16,2'b00}.
  - else: pc4.
- Priority is jr > jump/jal > branch > sequential when multiple flags are asserted.
- is_jal=1 with is_jump=0 is still treated as a jump.
- Link: when an accepted instruction has is_jal=1, ra_wr_en=1 and ra_wr_data=pc4 (of the accepted instruction) for exactly the one cycle following acceptance. ra_wr_data holds its value afterwards.
- align_err and ra_wr_en are registered pulses, asserted the cycle after acceptance.
- Throughput: minimum 2 cycles per instruction (1 FETCH with immediate ack + 1 DECODE with immediate valid).
- pc pc wraps 0xFFFF_FFFC -> 0x0000_0000 on sequential advance.

Optional Feature:
Macro: PC_SEQ_DELAY_SLOT_EN
- Defined: MIPS branch delay slot.
  - A taken transfer (jr/jump/branch) stores its target in a pending register; the next pc is pc4.
  - The following accepted instruction (the delay slot) then loads pc from the pending target.
  - Link address becomes pc+8.
  - Transfer flags on the delay-slot instruction are ignored; its link still fires if is_jal=1.
  - Reset clears the pending register.
- Undefined: transfers take effect immediately as above; link=pc+4.

Test Plan:
1. RESET_PC=0x0040_0000; release rst_n -> pc=0x0040_0000, fetch_req=0 for one cycle (BOOT), then 1 until fetch_ack.
2. Sequential: accept instruction with no flags at pc=0x0040_0000 -> pc=0x0040_0004 in FETCH; fetch_ack held low 3 cycles -> pc and fetch_req stable; instr_valid delayed 2 cycles in DECODE -> pc unchanged until accept.
3. Branch at pc=0x0040_0010: imm16=0xFFFF -> pc=0x0040_0010; imm16=0x0003 -> pc=0x0040_0020; is_branch=0 -> pc=0x0040_0014.
4. JAL at pc=0x0040_0008, target26=0x010_0000 -> pc=0x0040_0000; ra_wr_en pulse one cycle with ra_wr_data=0x0040_000C. Variant with is_jal=1, is_jump=1, is_jr=1 -> JR wins, link still written.
5. JR rs_data=0x0040_0023 -> pc=0x0040_0020 with align_err one-cycle pulse; rs_data=0x1234_5678 -> pc=0x1234_5678, no align_err.
6. Assert rst_n=0 mid-FETCH with fetch_req=1 -> fetch_req=0 and pc=RESET_PC before next clk edge; with PC_SEQ_DELAY_SLOT_EN, branch then reset -> pending target discarded, first post-reset fetch at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Purpose: program-counter sequencer; fetches, accepts one decoded instruction per fetch, computes next pc and JAL link.
// Latency: min 2 cycles/instr (FETCH + DECODE); ra_wr_en/align_err are registered pulses one cycle after acceptance.
// Backpressure: holds in FETCH until fetch_ack, holds in DECODE until instr_valid; pc stable while holding.
// Optional macro PC_SEQ_DELAY_SLOT_EN: MIPS branch delay slot (pending target, link = pc+8).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    input  logic        fetch_ack,
    output logic [31:0] pc,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        is_jump,
    input  logic        is_jal,
    input  logic        is_jr,
    input  logic        is_branch,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    output logic        ra_wr_en,
    output logic [31:0] ra_wr_data,
    output logic        align_err
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_ra_wr_en;
    logic [31:0] r_ra_wr_data;
    logic        r_align_err;

    logic        w_accept;
    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic        w_xfer;
    logic [31:0] w_xfer_tgt;
    logic        w_misalign;
    logic [31:0] w_next_pc;
    logic [31:0] w_link;
    logic        w_align_evt;

    // State register; reset abandons any fetch in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; acks/valids outside their state are ignored.
    always_comb begin
        w_state_nxt = r_state;
        fetch_req   = 1'b0;
        instr_ready = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign w_pc4    = r_pc + 32'd4;
    assign w_br_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Control-transfer target with priority jr > jump/jal > branch.
    always_comb begin
        w_xfer     = 1'b0;
        w_xfer_tgt = w_pc4;
        w_misalign = 1'b0;
        if (is_jr) begin
            w_xfer     = 1'b1;
            w_xfer_tgt = {rs_data[31:2], 2'b00};
            w_misalign = |rs_data[1:0];
        end else if (is_jump || is_jal) begin
            w_xfer     = 1'b1;
            w_xfer_tgt = {w_pc4[31:28], target26, 2'b00};
        end else if (is_branch) begin
            w_xfer     = 1'b1;
            w_xfer_tgt = w_pc4 + w_br_off;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic        r_pend_vld;
    logic [31:0] r_pend_pc;

    // Delay slot: a transfer only redirects after the next instruction; the slot's own flags are ignored.
    always_comb begin
        w_next_pc   = r_pend_vld ? r_pend_pc : w_pc4;
        w_link      = r_pc + 32'd8;
        w_align_evt = w_misalign && !r_pend_vld;
    end

    // Pending target register, armed by a transfer and consumed by the delay-slot instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_pc  <= 32'd0;
        end else if (w_accept) begin
            if (r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end else if (w_xfer) begin
                r_pend_vld <= 1'b1;
                r_pend_pc  <= w_xfer_tgt;
            end
        end
    end
`else
    // Transfers redirect immediately; link is the return address pc+4.
    always_comb begin
        w_next_pc   = w_xfer ? w_xfer_tgt : w_pc4;
        w_link      = w_pc4;
        w_align_evt = w_misalign;
    end
`endif

    // Program counter advances only when an instruction is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_accept) begin
            r_pc <= w_next_pc;
        end
    end

    // One-cycle link-write and alignment-error pulses; link data holds between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra_wr_en   <= 1'b0;
            r_ra_wr_data <= 32'd0;
            r_align_err  <= 1'b0;
        end else begin
            r_ra_wr_en  <= w_accept && is_jal;
            r_align_err <= w_accept && w_align_evt;
            if (w_accept && is_jal) begin
                r_ra_wr_data <= w_link;
            end
        end
    end

    assign pc         = r_pc;
    assign ra_wr_en   = r_ra_wr_en;
    assign ra_wr_data = r_ra_wr_data;
    assign align_err  = r_align_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed self-checking bench for pc_sequencer (default build, no delay slot).
// Latency: inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
// Backpressure: fetch_ack and instr_valid are delayed by explicit wait counts per step.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        fetch_ack;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        is_jump;
    logic        is_jal;
    logic        is_jr;
    logic        is_branch;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_data;
    logic        ra_wr_en;
    logic [31:0] ra_wr_data;
    logic        align_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(.RESET_PC(32'h0040_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_ack   (fetch_ack),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .is_jump     (is_jump),
        .is_jal      (is_jal),
        .is_jr       (is_jr),
        .is_branch   (is_branch),
        .imm16       (imm16),
        .target26    (target26),
        .rs_data     (rs_data),
        .ra_wr_en    (ra_wr_en),
        .ra_wr_data  (ra_wr_data),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while in FETCH; leaves the DUT in DECODE.
    task automatic do_fetch(input int waits, input logic [31:0] exp_pc);
        for (int i = 0; i < waits; i++) begin
            check("fetch_req_hold", {31'd0, fetch_req}, 32'd1);
            check("pc_hold_fetch", pc, exp_pc);
            @(negedge clk);
        end
        check("fetch_req", {31'd0, fetch_req}, 32'd1);
        check("pc_fetch", pc, exp_pc);
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        check("instr_ready", {31'd0, instr_ready}, 32'd1);
        check("fetch_req_decode", {31'd0, fetch_req}, 32'd0);
    endtask

    // Called at a falling edge while in DECODE; leaves the DUT one cycle after acceptance.
    task automatic do_decode(input int waits, input logic [31:0] exp_pc,
                             input logic j, input logic jal, input logic jr, input logic br,
                             input logic [15:0] imm, input logic [25:0] t26, input logic [31:0] rs);
        for (int i = 0; i < waits; i++) begin
            check("instr_ready_hold", {31'd0, instr_ready}, 32'd1);
            check("pc_hold_decode", pc, exp_pc);
            @(negedge clk);
        end
        is_jump = j; is_jal = jal; is_jr = jr; is_branch = br;
        imm16 = imm; target26 = t26; rs_data = rs;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        is_jump = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_branch = 1'b0;
    endtask

    task automatic step(input int fw, input logic [31:0] pc0, input int dw,
                        input logic j, input logic jal, input logic jr, input logic br,
                        input logic [15:0] imm, input logic [25:0] t26, input logic [31:0] rs,
                        input logic [31:0] exp_pc, input logic exp_ra_en,
                        input logic [31:0] exp_ra_dat, input logic exp_aerr);
        do_fetch(fw, pc0);
        do_decode(dw, pc0, j, jal, jr, br, imm, t26, rs);
        check("next_pc", pc, exp_pc);
        check("back_to_fetch", {31'd0, fetch_req}, 32'd1);
        check("ra_wr_en", {31'd0, ra_wr_en}, {31'd0, exp_ra_en});
        check("ra_wr_data", ra_wr_data, exp_ra_dat);
        check("align_err", {31'd0, align_err}, {31'd0, exp_aerr});
    endtask

    initial begin
        rst_n = 1'b1; fetch_ack = 1'b0; instr_valid = 1'b0;
        is_jump = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_branch = 1'b0;
        imm16 = 16'd0; target26 = 26'd0; rs_data = 32'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_ra_wr_en", {31'd0, ra_wr_en}, 32'd0);
        check("rst_ra_wr_data", ra_wr_data, 32'd0);
        check("rst_align_err", {31'd0, align_err}, 32'd0);

        rst_n = 1'b1;
        check("boot_fetch_req", {31'd0, fetch_req}, 32'd0);
        @(negedge clk);

        //   fw  pc0            dw  j    jal  jr   br   imm       t26          rs              exp_pc         ra  ra_dat         aerr
        step(3, 32'h0040_0000, 2, 1'b0,1'b0,1'b0,1'b0, 16'h0000, 26'h000_0000, 32'h0000_0000, 32'h0040_0004, 1'b0, 32'h0000_0000, 1'b0);
        step(0, 32'h0040_0004, 0, 1'b1,1'b0,1'b0,1'b0, 16'h0000, 26'h010_0004, 32'h0000_0000, 32'h0040_0010, 1'b0, 32'h0000_0000, 1'b0);
        step(0, 32'h0040_0010, 0, 1'b0,1'b0,1'b0,1'b1, 16'hFFFF, 26'h000_0000, 32'h0000_0000, 32'h0040_0010, 1'b0, 32'h0000_0000, 1'b0);
        step(0, 32'h0040_0010, 0, 1'b0,1'b0,1'b0,1'b1, 16'h0003, 26'h000_0000, 32'h0000_0000, 32'h0040_0020, 1'b0, 32'h0000_0000, 1'b0);
        step(0, 32'h0040_0020, 0, 1'b1,1'b0,1'b0,1'b0, 16'h0000, 26'h010_0004, 32'h0000_0000, 32'h0040_0010, 1'b0, 32'h0000_0000, 1'b0);
        step(0, 32'h0040_0010, 0, 1'b0,1'b0,1'b0,1'b0, 16'h0003, 26'h000_0000, 32'h0000_0000, 32'h0040_0014, 1'b0, 32'h0000_0000, 1'b0);
        step(0, 32'h0040_0014, 0, 1'b1,1'b0,1'b0,1'b0, 16'h0000, 26'h010_0002, 32'h0000_0000, 32'h0040_0008, 1'b0, 32'h0000_0000, 1'b0);
        step(0, 32'h0040_0008, 0, 1'b1,1'b1,1'b0,1'b0, 16'h0000, 26'h010_0000, 32'h0000_0000, 32'h0040_0000, 1'b1, 32'h0040_000C, 1'b0);
        @(negedge clk);
        check("ra_pulse_end", {31'd0, ra_wr_en}, 32'd0);
        check("ra_data_hold", ra_wr_data, 32'h0040_000C);
        step(0, 32'h0040_0000, 0, 1'b1,1'b1,1'b1,1'b0, 16'h0000, 26'h010_0000, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0040_0004, 1'b0);
        step(0, 32'h1234_5678, 0, 1'b0,1'b1,1'b0,1'b0, 16'h0000, 26'h010_0000, 32'h0000_0000, 32'h1040_0000, 1'b1, 32'h1234_567C, 1'b0);
        step(0, 32'h1040_0000, 0, 1'b0,1'b0,1'b1,1'b0, 16'h0000, 26'h000_0000, 32'h0040_0023, 32'h0040_0020, 1'b0, 32'h1234_567C, 1'b1);
        @(negedge clk);
        check("align_pulse_end", {31'd0, align_err}, 32'd0);
        step(0, 32'h0040_0020, 0, 1'b1,1'b0,1'b0,1'b1, 16'h0003, 26'h010_0004, 32'h0000_0000, 32'h0040_0010, 1'b0, 32'h1234_567C, 1'b0);
        step(0, 32'h0040_0010, 0, 1'b0,1'b0,1'b1,1'b1, 16'h0003, 26'h000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h1234_567C, 1'b0);
        step(0, 32'hFFFF_FFFC, 0, 1'b0,1'b0,1'b0,1'b0, 16'h0000, 26'h000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1234_567C, 1'b0);

        // instr_valid during FETCH must not advance pc
        instr_valid = 1'b1; is_jr = 1'b1; rs_data = 32'h0000_0100;
        @(negedge clk);
        instr_valid = 1'b0; is_jr = 1'b0;
        check("valid_in_fetch_pc", pc, 32'h0000_0000);
        check("valid_in_fetch_req", {31'd0, fetch_req}, 32'd1);
        do_fetch(0, 32'h0000_0000);
        // fetch_ack during DECODE must not leave DECODE
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        check("ack_in_decode_rdy", {31'd0, instr_ready}, 32'd1);
        check("ack_in_decode_pc", pc, 32'h0000_0000);
        do_decode(0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h000_0000, 32'h0);
        check("pc_before_rst", pc, 32'h0000_0004);
        check("fetch_before_rst", {31'd0, fetch_req}, 32'd1);

        // asynchronous reset mid-FETCH, between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("async_rst_pc", pc, 32'h0040_0000);
        check("async_rst_ra_data", ra_wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_boot", {31'd0, fetch_req}, 32'd0);
        @(negedge clk);
        do_fetch(0, 32'h0040_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
